// File: rtl/dmem_access_pkg.sv
// Shared types, funct3 encodings and store-lane helpers for the MEM-stage data-memory access unit.
package dmem_access_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_e;

   localparam logic [2:0] LB  = 3'd0;
   localparam logic [2:0] LH  = 3'd1;
   localparam logic [2:0] LW  = 3'd2;
   localparam logic [2:0] LBU = 3'd4;
   localparam logic [2:0] LHU = 3'd5;
   localparam logic [2:0] SB  = 3'd0;
   localparam logic [2:0] SH  = 3'd1;
   localparam logic [2:0] SW  = 3'd2;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
      logic [2:0]      funct3;
      logic            is_store;
   } req_t;

   // size is funct3[1:0]: 00 byte, 01 half, 10 word
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b10:   return off != 2'b00;
         2'b01:   return off[0];
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   return 4'b0001 << off;
         2'b01:   return 4'b0011 << {off[1], 1'b0};
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] store_data(input logic [1:0] size, input logic [XLEN-1:0] wdata);
      case (size)
         2'b00:   return {4{wdata[7:0]}};
         2'b01:   return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      return (cnt == '1) ? cnt : cnt + CNT_W'(1);
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Selects the addressed byte/half from a cache word and sign- or zero-extends it.
module dmem_load_align
   import dmem_access_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] load_data_c
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'(rdata >> {offset, 3'b000});
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         LB:      load_data_c = {{24{byte_sel[7]}}, byte_sel};
         LBU:     load_data_c = {24'h0, byte_sel};
         LH:      load_data_c = {{16{half_sel[15]}}, half_sel};
         LHU:     load_data_c = {16'h0, half_sel};
         default: load_data_c = rdata;
      endcase
   end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit: issues one held cache request per load/store,
// returns a one-cycle dmem_resp with aligned load data, flags misalignment, counts activity.
module dmem_access_unit
   import dmem_access_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             dmem_read,
   input  logic             dmem_write,
   input  logic [XLEN-1:0]  mem_addr_i,
   input  logic [XLEN-1:0]  mem_wdata_i,
   input  logic [2:0]       funct3_i,
   output logic             dmem_resp,
   output logic [XLEN-1:0]  load_data,
   output logic             misalign,
   output logic [XLEN-1:0]  mem_address,
   output logic             mem_read,
   output logic             mem_write,
   output logic [3:0]       mem_wmask,
   output logic [XLEN-1:0]  mem_wdata,
   input  logic [XLEN-1:0]  mem_rdata,
   input  logic             mem_resp,
   input  logic             clear_counters,
   output logic [CNT_W-1:0] load_count,
   output logic [CNT_W-1:0] store_count,
   output logic [CNT_W-1:0] stall_count
);

   state_e          state_q, state_d;
   req_t            req_q, req_d, req_in, issue;
   logic            dropped_q, dropped_d;
   logic            req_valid_c;
   logic [XLEN-1:0] aligned_c;

   logic            dmem_resp_d, misalign_d, mem_read_d, mem_write_d;
   logic [XLEN-1:0] load_data_d, mem_address_d, mem_wdata_d;
   logic [3:0]      mem_wmask_d;

   dmem_load_align u_align (
      .rdata       (mem_rdata),
      .offset      (req_q.addr[1:0]),
      .funct3      (req_q.funct3),
      .load_data_c (aligned_c)
   );

   always_comb begin
      req_valid_c = dmem_read | dmem_write;
      req_in      = '{addr: mem_addr_i, wdata: mem_wdata_i, funct3: funct3_i, is_store: dmem_write};
      issue       = (state_q == IDLE) ? req_in : req_q;
   end

   // Next state and next registered outputs; cache-side fields are rebuilt from the issuing request.
   always_comb begin
      state_d       = state_q;
      req_d         = req_q;
      dropped_d     = dropped_q;
      dmem_resp_d   = 1'b0;
      load_data_d   = '0;
      misalign_d    = 1'b0;
      mem_address_d = '0;
      mem_read_d    = 1'b0;
      mem_write_d   = 1'b0;
      mem_wmask_d   = 4'b0000;
      mem_wdata_d   = '0;
      case (state_q)
         IDLE: begin
            if (req_valid_c) begin
               req_d = req_in;
               if (is_misaligned(funct3_i[1:0], mem_addr_i[1:0])) begin
                  state_d     = DONE;
                  dmem_resp_d = 1'b1;
                  misalign_d  = 1'b1;
               end else begin
                  state_d   = WAIT;
                  dropped_d = 1'b0;
               end
            end
         end
         WAIT: begin
            if (!req_valid_c) dropped_d = 1'b1;
            if (mem_resp) begin
               // An abandoned request still finishes its cache transaction, silently.
               if (dropped_q || !req_valid_c) begin
                  state_d = IDLE;
               end else begin
                  state_d     = DONE;
                  dmem_resp_d = 1'b1;
                  load_data_d = req_q.is_store ? '0 : aligned_c;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_d == WAIT) begin
         mem_address_d = {issue.addr[XLEN-1:2], 2'b00};
         mem_read_d    = !issue.is_store;
         mem_write_d   = issue.is_store;
         mem_wmask_d   = issue.is_store ? store_mask(issue.funct3[1:0], issue.addr[1:0]) : 4'b0000;
         mem_wdata_d   = issue.is_store ? store_data(issue.funct3[1:0], issue.wdata) : '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         req_q       <= '0;
         dropped_q   <= 1'b0;
         dmem_resp   <= 1'b0;
         load_data   <= '0;
         misalign    <= 1'b0;
         mem_address <= '0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_wmask   <= 4'b0000;
         mem_wdata   <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         dropped_q   <= dropped_d;
         dmem_resp   <= dmem_resp_d;
         load_data   <= load_data_d;
         misalign    <= misalign_d;
         mem_address <= mem_address_d;
         mem_read    <= mem_read_d;
         mem_write   <= mem_write_d;
         mem_wmask   <= mem_wmask_d;
         mem_wdata   <= mem_wdata_d;
      end
   end

   // Saturating perf counters; completions counted during the DONE cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         load_count  <= '0;
         store_count <= '0;
         stall_count <= '0;
      end else if (clear_counters) begin
         load_count  <= '0;
         store_count <= '0;
         stall_count <= '0;
      end else begin
         if (state_q == DONE && !misalign) begin
            if (req_q.is_store) store_count <= sat_inc(store_count);
            else                load_count  <= sat_inc(load_count);
         end
         if (state_q == WAIT) stall_count <= sat_inc(stall_count);
      end
   end

endmodule
